// File: rtl/bob_ind_sched_if.sv
// rtl/bob_ind_sched_if.sv - allocation, ready-set, buffer-port and retire signals of bob_ind_sched
interface bob_ind_sched_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 65
);
  logic                  alloc0_req;
  logic                  alloc1_req;
  logic                  alloc0_gnt;
  logic                  alloc1_gnt;
  logic [ADDR_WIDTH-1:0] alloc_idx;
  logic                  ext_rdy_req;
  logic [ADDR_WIDTH-1:0] ext_rdy_addr;
  logic                  ext_rdy_ack;
  logic                  flush;
  logic                  read_clkEn;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_ready;
  logic [ADDR_WIDTH-1:0] writeI_addr;
  logic                  writeI_ready;
  logic                  writeI_wen;
  logic                  ret_valid;
  logic [ADDR_WIDTH-1:0] ret_idx;
  logic [DATA_WIDTH-1:0] ret_data;
  logic                  ret_ack;
  logic [ADDR_WIDTH:0]   count;
  logic                  empty;
  logic                  full;

  // scheduler side
  modport slave (
    input  alloc0_req, alloc1_req, ext_rdy_req, ext_rdy_addr, flush,
    input  read_data, read_ready, ret_ack,
    output alloc0_gnt, alloc1_gnt, alloc_idx, ext_rdy_ack,
    output read_clkEn, read_addr, writeI_addr, writeI_ready, writeI_wen,
    output ret_valid, ret_idx, ret_data, count, empty, full
  );

  // requesters, buffer and retire consumer side
  modport master (
    output alloc0_req, alloc1_req, ext_rdy_req, ext_rdy_addr, flush,
    output read_data, read_ready, ret_ack,
    input  alloc0_gnt, alloc1_gnt, alloc_idx, ext_rdy_ack,
    input  read_clkEn, read_addr, writeI_addr, writeI_ready, writeI_wen,
    input  ret_valid, ret_idx, ret_data, count, empty, full
  );
endinterface

// File: rtl/bob_ind_sched.sv
// rtl/bob_ind_sched.sv - in-order allocator and retire sequencer for the indirect result buffer
module bob_ind_sched #(
  parameter int ADDR_WIDTH = 3,
  parameter int ADDR_COUNT = 6,
  parameter int DATA_WIDTH = 65
) (
  input logic            clk,
  input logic            rst,
  bob_ind_sched_if.slave bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(ADDR_COUNT - 1);
  localparam logic [ADDR_WIDTH:0]   COUNT_MAX = (ADDR_WIDTH + 1)'(ADDR_COUNT);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_CHK, S_OUT} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  rr;
  logic                  ret_valid_q;
  logic [ADDR_WIDTH-1:0] ret_idx_q;
  logic [DATA_WIDTH-1:0] ret_data_q;

  logic                  full_w;
  logic                  gnt0;
  logic                  gnt1;
  logic                  grant;
  logic                  ext_ack;
  logic                  more_after_ret;
  logic [ADDR_WIDTH-1:0] head_inc;
  logic                  read_en;
  logic [ADDR_WIDTH-1:0] read_addr_c;
  logic                  capture;
  logic                  retire;

  // index increment that wraps at the last real entry, not at 2^ADDR_WIDTH
  function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == LAST_IDX) ? '0 : a + 1'b1;
  endfunction

  assign full_w         = (count_q == COUNT_MAX);
  assign head_inc       = wrap_inc(head);
  assign more_after_ret = (count_q > COUNT_ONE);
  assign grant          = gnt0 | gnt1;
  assign ext_ack        = bus.ext_rdy_req & ~grant;

  // two-way arbitration; rr breaks ties and always points away from the last winner
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!full_w && !bus.flush) begin
      if (bus.alloc0_req && bus.alloc1_req) begin
        gnt0 = ~rr;
        gnt1 = rr;
      end else begin
        gnt0 = bus.alloc0_req;
        gnt1 = bus.alloc1_req;
      end
    end
  end

  // single ready-write port: clearing a freshly allocated entry beats an external set
  always_comb begin
    bus.writeI_wen   = 1'b0;
    bus.writeI_addr  = tail;
    bus.writeI_ready = 1'b0;
    if (grant) begin
      bus.writeI_wen = 1'b1;
    end else if (ext_ack) begin
      bus.writeI_wen   = 1'b1;
      bus.writeI_addr  = bus.ext_rdy_addr;
      bus.writeI_ready = 1'b1;
    end
  end

  // retire FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // retire FSM next state; flush always returns to IDLE
  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (count_q != '0) state_next = S_CHK;
        S_CHK:   if (bus.read_ready) state_next = S_OUT;
        S_OUT:   if (bus.ret_ack) state_next = more_after_ret ? S_CHK : S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // retire FSM outputs: head polling, capture of a ready head, and retire on ack
  always_comb begin
    read_en     = 1'b0;
    read_addr_c = head;
    capture     = 1'b0;
    retire      = 1'b0;
    if (!bus.flush) begin
      case (state)
        S_IDLE: read_en = (count_q != '0);
        S_CHK: begin
          if (bus.read_ready) capture = 1'b1;
          else                read_en = 1'b1;
        end
        S_OUT: begin
          if (bus.ret_ack) begin
            retire = 1'b1;
            if (more_after_ret) begin
              read_en     = 1'b1;
              read_addr_c = head_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // pointers, occupancy, arbitration history and the presented retire entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      count_q     <= '0;
      rr          <= 1'b0;
      ret_valid_q <= 1'b0;
      ret_idx_q   <= '0;
      ret_data_q  <= '0;
    end else if (bus.flush) begin
      head        <= '0;
      tail        <= '0;
      count_q     <= '0;
      ret_valid_q <= 1'b0;
    end else begin
      if (grant) begin
        tail <= wrap_inc(tail);
        rr   <= gnt0;
      end
      if (retire) head <= head_inc;
      case ({grant, retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (capture) begin
        ret_valid_q <= 1'b1;
        ret_idx_q   <= head;
        ret_data_q  <= bus.read_data;
      end else if (retire) begin
        ret_valid_q <= 1'b0;
      end
    end
  end

  assign bus.alloc0_gnt  = gnt0;
  assign bus.alloc1_gnt  = gnt1;
  assign bus.alloc_idx   = tail;
  assign bus.ext_rdy_ack = ext_ack;
  assign bus.read_clkEn  = read_en;
  assign bus.read_addr   = read_addr_c;
  assign bus.ret_valid   = ret_valid_q;
  assign bus.ret_idx     = ret_idx_q;
  assign bus.ret_data    = ret_data_q;
  assign bus.count       = count_q;
  assign bus.empty       = (count_q == '0);
  assign bus.full        = full_w;
endmodule

// File: doc/bob_ind_sched.md
# bob_ind_sched

In-order allocator and retire sequencer for the indirect result buffer (the 65-bit data plus ready-bit storage indexed by bob address). It arbitrates two allocation requesters and an external ready-set requester onto the buffer's single ready-only write port (writeI). It owns the buffer's registered read port to poll the head entry and hands completed entries downstream in allocation order. It sits between the dispatch-side allocators and the retire consumer; the data write port stays with the producing unit.

## Interface
- ADDR_WIDTH, `bob_addr_width, entry index width
- ADDR_COUNT, `bob_count, number of entries, need not be a power of two, at most 2^ADDR_WIDTH
- DATA_WIDTH, 65, entry data width
- clk  in  1  clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- alloc0_req / alloc1_req  in  1  requester 0/1 wants one entry this cycle
- alloc0_gnt / alloc1_gnt  out  1  grant; combinational, at most one high per cycle
- alloc_idx  out  ADDR_WIDTH  index handed to the granted requester (= tail)
- ext_rdy_req  in  1  request to force the ready bit of ext_rdy_addr to 1
- ext_rdy_addr  in  ADDR_WIDTH  target entry
- ext_rdy_ack  out  1  ext request wins writeI this cycle
- flush  in  1  discard all entries
- read_clkEn  out  1  buffer read-address load enable
- read_addr  out  ADDR_WIDTH  buffer read address
- read_data  in  DATA_WIDTH  buffer data for the registered read address
- read_ready  in  1  buffer ready bit for the registered read address
- writeI_addr  out  ADDR_WIDTH  buffer ready-write index
- writeI_ready  out  1  ready value written
- writeI_wen  out  1  ready-write enable
- ret_valid  out  1  head entry is ready and presented
- ret_idx  out  ADDR_WIDTH  index of the presented entry
- ret_data  out  DATA_WIDTH  data of the presented entry
- ret_ack  in  1  consumer takes the presented entry
- count  out  ADDR_WIDTH+1  entries currently allocated
- empty / full  out  1  count==0 / count==ADDR_COUNT

## Operation
- **State:** head, tail (ADDR_WIDTH), count, rr (1 bit), FSM {IDLE, CHK, OUT}, plus ret_valid/ret_idx/ret_data registers. Head and tail increment wrap from ADDR_COUNT-1 to 0.
- **Allocation:**
  - Grants are blocked when full, or when flush is high.
  - If exactly one requester is active, it is granted.
  - If both are active, the requester selected by rr (0 → alloc0) is granted.
  - After any grant, rr points to the other requester.
  - On a grant, the same cycle drives writeI_wen=1, writeI_addr=tail, writeI_ready=0 (clears the stale ready bit). At the edge: tail+1, count+1.
- **External ready-set:**
  - ext_rdy_ack = ext_rdy_req & no grant this cycle. An allocation clear has priority.
  - When acked: writeI_wen=1, writeI_addr=ext_rdy_addr, writeI_ready=1.
  - The requester holds its request until acked.
- **Retire FSM:**
  - IDLE: if count>0 (and no flush), assert read_clkEn, read_addr=head, go to CHK.
  - CHK: read_data/read_ready refer to head.
    - If read_ready=1: capture ret_data←read_data, ret_idx←head, ret_valid←1, go to OUT.
    - Otherwise: reassert read_clkEn with read_addr=head (poll every cycle) and stay in CHK.
  - OUT: ret_valid=1, and ret_data is held while waiting.
    - On ret_ack: head+1, count-1, ret_valid←0.
    - If count-1>0, assert read_clkEn with read_addr=head+1 and go to CHK. Otherwise go to IDLE.
- **read_clkEn** is 0 in every case not listed above.
- **Simultaneous grant and retire:** count unchanged. Full blocks a grant even when a retire happens the same cycle.
- **flush:**
  - At the edge: head←tail←0, count←0, ret_valid←0, FSM←IDLE.
  - flush overrides ret_ack and any grant in the same cycle.
  - ext_rdy still proceeds during flush.
- **Reset values:** head=tail=count=0, rr=0, FSM=IDLE, ret_valid=0, ret_idx=0, ret_data=0. Hence empty=1, full=0, read_clkEn=0, writeI_wen=0. Asserting rst mid-operation returns all of this state to the reset values immediately.

## Timing
- Grant, alloc_idx, ext_rdy_ack and the writeI_* outputs are combinational from the request inputs and the current state. Their state effects take place at the next edge.
- Retire latency:
  - The head's ready bit is written at edge E while the FSM is in CHK.
  - The poll also reloads the read address at E, so read_ready=1 in cycle E+1.
  - Capture happens at edge E+1, so ret_valid=1 from E+1 until the ack edge.
- Retire throughput is one entry per 2 cycles (OUT→CHK→OUT).
- A retired entry's index can be granted again in the cycle after its ack edge at the earliest.

## Test plan
- Reset, then ADDR_COUNT=6 bench, with alloc0 and alloc1 held high for 6 cycles → grants alternate 0,1,0,1,0,1; alloc_idx 0..5; each grant cycle has writeI_wen=1, writeI_ready=0; full=1 and both gnt=0 on cycle 7.
- Allocate idx 0 → read_clkEn polls head 0 every cycle, ret_valid=0. Then set ready via ext_rdy_addr=0 → ext_rdy_ack=1, ret_valid=1 two cycles later, ret_idx=0. Holding ret_ack low for 3 cycles keeps ret_data stable.
- Fill 6, retire 4, allocate 3 → alloc_idx 0,1,2 (wrap); retire order continues 4,5,0.
- Full and retire-ack in the same cycle with alloc0_req=1 → no grant, count goes 6→5; the grant happens the next cycle.
- alloc0_req and ext_rdy_req in the same cycle → alloc0_gnt=1, ext_rdy_ack=0; the next cycle ext_rdy_ack=1 with writeI_ready=1.
- With ret_valid=1, flush and ret_ack in the same cycle → count=0, empty=1, ret_valid=0, head=tail=0. Then assert rst asynchronously mid-poll → read_clkEn drops immediately.
